host_uart_rsp_serializer: RTL and testbench

//  Downstream stage of the host UART response encoder. Latches one encoded response frame
//  (wide vector + byte length) and streams it LSB-byte-first to the UART transmitter over a

---
 rtl/host_uart_rsp_serializer_if.sv | 46 ++++
 rtl/host_uart_rsp_serializer.sv | 163 ++++++++++++++++
 tb/tb_host_uart_rsp_serializer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_uart_rsp_serializer_if.sv
// ---------------------------------------------------------------------------------------------
// host_uart_rsp_serializer_if
//   Bundles the two handshake channels of the response serializer.
//   Frame channel (upstream -> serializer):
//     frame_data   encoded frame, byte k = frame_data[8k+7:8k]
//     frame_len    number of payload bytes
//     frame_valid  frame_data/frame_len valid
//     frame_ready  serializer can take a frame
//   Byte channel (serializer -> UART TX):
//     tx_byte      byte to transmit
//     tx_valid     tx_byte valid
//     tx_ready     transmitter accepts byte on tx_valid & tx_ready
//   Modports: master = upstream/transmitter side, slave = serializer.
// ---------------------------------------------------------------------------------------------
interface host_uart_rsp_serializer_if #(
    parameter int unsigned MAX_BYTES = 128,
    parameter int unsigned LEN_W     = 8
);
    logic [MAX_BYTES*8-1:0] frame_data;
    logic [LEN_W-1:0]       frame_len;
    logic                   frame_valid;
    logic                   frame_ready;
    logic [7:0]             tx_byte;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (
        output frame_data,
        output frame_len,
        output frame_valid,
        input  frame_ready,
        input  tx_byte,
        input  tx_valid,
        output tx_ready
    );

    modport slave (
        input  frame_data,
        input  frame_len,
        input  frame_valid,
        output frame_ready,
        output tx_byte,
        output tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/host_uart_rsp_serializer.sv
// ---------------------------------------------------------------------------------------------
// host_uart_rsp_serializer
//   Latches one encoded response frame and streams it LSB-byte-first to the UART transmitter.
//   Frames with length 0 or above MAX_BYTES are dropped with a one-cycle error pulse; every
//   completed frame produces a one-cycle done pulse.
//   Optional feature: define HOST_UART_RSP_CHECKSUM_EN to append an XOR checksum byte after
//   the payload (wire byte count = frame_len + 1).
// Ports:
//   clk    system clock, all logic on posedge
//   reset  synchronous active-low reset
//   bus    frame input channel and tx byte output channel (slave modport)
//   busy   high while a frame is being loaded or sent
//   done   one-cycle pulse after the final byte handshake
//   error  one-cycle pulse on a rejected frame
// ---------------------------------------------------------------------------------------------
module host_uart_rsp_serializer #(
    parameter int unsigned MAX_BYTES = 128,
    parameter int unsigned LEN_W     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    host_uart_rsp_serializer_if.slave        bus,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int unsigned DataW = MAX_BYTES * 8;
    localparam int unsigned SelW  = $clog2(DataW);

`ifdef HOST_UART_RSP_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StLoad, StSend, StCsum} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;
`endif

    state_e             state_q, state_d;
    logic [DataW-1:0]   shadow_q, shadow_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_valid_q, tx_valid_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
`ifdef HOST_UART_RSP_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               len_bad;
    logic               last_byte;
    logic [LEN_W-1:0]   idx_nxt;
    logic [SelW-1:0]    sel_nxt;

    // Length is checked one bit wider so MAX_BYTES itself is never truncated.
    assign len_bad   = (bus.frame_len == '0) ||
                       ({1'b0, bus.frame_len} > (LEN_W + 1)'(MAX_BYTES));
    assign last_byte = (idx_q == len_q - LEN_W'(1));
    assign idx_nxt   = idx_q + LEN_W'(1);
    assign sel_nxt   = SelW'({idx_nxt, 3'b000});

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        len_d      = len_q;
        idx_d      = idx_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
`ifdef HOST_UART_RSP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.frame_valid) begin
                    if (len_bad) begin
                        error_d = 1'b1;
                    end else begin
                        shadow_d = bus.frame_data;
                        len_d    = bus.frame_len;
                        idx_d    = '0;
`ifdef HOST_UART_RSP_CHECKSUM_EN
                        csum_d   = 8'h00;
`endif
                        state_d  = StLoad;
                    end
                end
            end
            StLoad: begin
                tx_byte_d  = shadow_q[7:0];
                tx_valid_d = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                if (tx_valid_q && bus.tx_ready) begin
`ifdef HOST_UART_RSP_CHECKSUM_EN
                    csum_d = csum_q ^ tx_byte_q;
`endif
                    if (last_byte) begin
`ifdef HOST_UART_RSP_CHECKSUM_EN
                        // Checksum byte follows immediately; tx_valid stays high.
                        tx_byte_d = csum_q ^ tx_byte_q;
                        state_d   = StCsum;
`else
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = StIdle;
`endif
                    end else begin
                        idx_d     = idx_nxt;
                        tx_byte_d = shadow_q[sel_nxt +: 8];
                    end
                end
            end
`ifdef HOST_UART_RSP_CHECKSUM_EN
            StCsum: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            shadow_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef HOST_UART_RSP_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef HOST_UART_RSP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.frame_ready = (state_q == StIdle);
    assign bus.tx_byte     = tx_byte_q;
    assign bus.tx_valid    = tx_valid_q;
    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_host_uart_rsp_serializer.sv
module tb_host_uart_rsp_serializer;

    localparam int unsigned MB = 128;
    localparam int unsigned LW = 8;

    logic clk;
    logic reset;
    logic busy, done, error;

    host_uart_rsp_serializer_if #(.MAX_BYTES(MB), .LEN_W(LW)) bus ();

    host_uart_rsp_serializer #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {is_last_wire_byte, byte}
    logic [8:0] exp_q[$];
    int         n_popped = 0;
    int         done_count = 0;
    int         frames_expected = 0;
    logic       expect_done = 1'b0;
    int         rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the wire carries payload bytes 0..len-1 in order, optionally followed
    // by the XOR of all of them.
    function automatic void push_expected(input logic [MB*8-1:0] d, input int len);
        logic [7:0] x;
        logic [7:0] b;
        logic       csum_en;
`ifdef HOST_UART_RSP_CHECKSUM_EN
        csum_en = 1'b1;
`else
        csum_en = 1'b0;
`endif
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
            b = d[8*k +: 8];
            x = x ^ b;
            exp_q.push_back({(k == len - 1) && !csum_en, b});
        end
        if (csum_en) exp_q.push_back({1'b1, x});
    endfunction

    function automatic logic [MB*8-1:0] rand_data();
        logic [MB*8-1:0] d;
        for (int i = 0; i < int'(MB) / 4; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Transmitter ready generator
    initial begin
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ~bus.tx_ready;
                default: bus.tx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops and compares on every byte handshake, checks stall stability and done timing
    initial begin
        logic       prev_valid;
        logic       prev_ready;
        logic [7:0] prev_byte;
        logic [8:0] e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid  = 1'b0;
                expect_done = 1'b0;
                continue;
            end
            if (done || expect_done) chk("done_timing", {31'd0, done}, {31'd0, expect_done});
            if (done) done_count++;
            if (error && done) chk("done_error_overlap", 32'd1, 32'd0);
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
                chk("stall_byte", {24'd0, bus.tx_byte}, {24'd0, prev_byte});
            end
            expect_done = 1'b0;
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, bus.tx_byte}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {24'd0, bus.tx_byte}, {24'd0, e[7:0]});
                    n_popped++;
                    expect_done = e[8];
                end
            end
            prev_valid = bus.tx_valid;
            prev_ready = bus.tx_ready;
            prev_byte  = bus.tx_byte;
        end
    end

    task automatic send_frame(input logic [MB*8-1:0] d, input int len);
        int t;
        bus.frame_data  = d;
        bus.frame_len   = LW'(len);
        bus.frame_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (bus.frame_ready) break;
            t++;
            if (t > 3000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=frame_ready_low expected=frame_ready_high");
                bus.frame_valid = 1'b0;
                return;
            end
        end
        push_expected(d, len);
        frames_expected++;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        bus.frame_data  = rand_data();
        bus.frame_len   = LW'($urandom);
    endtask

    task automatic send_bad(input int len);
        bus.frame_data  = rand_data();
        bus.frame_len   = LW'(len);
        bus.frame_valid = 1'b1;
        @(negedge clk);
        chk("bad_ready_before", {31'd0, bus.frame_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        chk("bad_error_pulse", {31'd0, error}, 32'd1);
        chk("bad_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("bad_ready_after", {31'd0, bus.frame_ready}, 32'd1);
        chk("bad_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("bad_error_clear", {31'd0, error}, 32'd0);
        chk("bad_tx_valid2", {31'd0, bus.tx_valid}, 32'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && !expect_done && bus.frame_ready)) begin
            @(posedge clk);
            t++;
            if (t > 3000) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout actual=%0d_bytes_pending expected=0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MB*8-1:0] d;
        int base;
        int t;

        reset           = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        bus.frame_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frame_ready", {31'd0, bus.frame_ready}, 32'd1);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Encrypt response, back-to-back at full rate
        rdy_mode = 0;
        d = '0;
        d[7:0] = 8'h02;
        base = n_popped;
        send_frame(d, 8);
        @(posedge clk);
        #1;
        chk("first_byte_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("first_byte_value", {24'd0, bus.tx_byte}, 32'h02);
        chk("busy_in_send", {31'd0, busy}, 32'd1);
        repeat (8) @(posedge clk);
        chk("back_to_back", n_popped - base, 32'd8);
        wait_idle();

        // Yaw response with toggling ready
        rdy_mode = 1;
        d = '0;
        d[7:0]    = 8'h04;
        d[87:56]  = 32'hDDCC_BBAA;
        d[95:88]  = 8'h01;
        send_frame(d, 12);
        wait_idle();

        // Malformed lengths
        rdy_mode = 0;
        send_bad(0);
        send_bad(int'(MB) + 1);

        // New frame offered while busy is ignored
        d = rand_data();
        send_frame(d, 8);
        repeat (2) @(posedge clk);
        #1;
        bus.frame_valid = 1'b1;
        bus.frame_data  = rand_data();
        bus.frame_len   = LW'(5);
        @(negedge clk);
        chk("ready_low_busy", {31'd0, bus.frame_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.frame_valid = 1'b0;
        wait_idle();

        // Reset after the third byte aborts the frame
        d = rand_data();
        base = n_popped;
        send_frame(d, 8);
        t = 0;
        while (n_popped < base + 3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        reset = 1'b0;
        exp_q.delete();
        frames_expected--;
        @(posedge clk);
        #1;
        chk("abort_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, bus.frame_ready}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_frame(rand_data(), 8);
        wait_idle();

        // Maximum-length frame
        rdy_mode = 2;
        d = {MB{8'hA5}};
        send_frame(d, int'(MB));
        wait_idle();

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            rdy_mode = (i % 3);
            send_frame(rand_data(), (i < 2) ? (i + 1) : int'($urandom_range(1, MB)));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        chk("done_count", done_count, frames_expected);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
